mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu_pkg.sv | 35 +++
 rtl/mem_stage_lsu_if.sv | 44 ++++
 rtl/mem_stage_lsu_load_extract.sv | 57 +++++
 rtl/mem_stage_lsu.sv | 139 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM stage load/store unit.
// Holds the load_op encodings, the load FSM state encodings, the default
// stall-bit indices and the alignment rule shared by the capture logic and
// the extractor.
package mem_stage_lsu_pkg;

    localparam int MEM_STALL_BIT_DEF = 3;
    localparam int WB_STALL_BIT_DEF  = 4;

    typedef enum logic [2:0] {
        LOAD_LW  = 3'd0,
        LOAD_LB  = 3'd1,
        LOAD_LBU = 3'd2,
        LOAD_LH  = 3'd3,
        LOAD_LHU = 3'd4
    } load_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Reserved encodings fall into the default arm and are treated as LW.
    function automatic logic load_misaligned(input logic [2:0] load_op, input logic [1:0] off);
        logic mis;
        case (load_op)
            LOAD_LB, LOAD_LBU: mis = 1'b0;
            LOAD_LH, LOAD_LHU: mis = off[0];
            default:           mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Bus bundle between the EX stage / data SRAM and the MEM stage, plus the
// WB and forwarding buses the MEM stage drives.
//   master : the environment (EX stage, SRAM, consumers of WB/fwd)
//   slave  : the MEM stage itself
interface mem_stage_lsu_if #(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5
);
    import mem_stage_lsu_pkg::*;

    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic              ex_mem_ren;
    logic [2:0]        ex_load_op;
    logic              ex_rf_we;
    logic [RF_AW-1:0]  ex_rf_waddr;
    logic [DATA_W-1:0] ex_result;
    logic              data_sram_rvalid;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              wb_valid;
    logic [31:0]       wb_pc;
    logic              wb_rf_we;
    logic [RF_AW-1:0]  wb_rf_waddr;
    logic [DATA_W-1:0] wb_rf_wdata;
    logic              fwd_we;
    logic [RF_AW-1:0]  fwd_waddr;
    logic [DATA_W-1:0] fwd_wdata;
    logic              fwd_load_pending;

    modport master (
        output ex_valid, ex_pc, ex_mem_ren, ex_load_op, ex_rf_we, ex_rf_waddr, ex_result,
        output data_sram_rvalid, data_sram_rdata,
        input  wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
        input  fwd_we, fwd_waddr, fwd_wdata, fwd_load_pending
    );

    modport slave (
        input  ex_valid, ex_pc, ex_mem_ren, ex_load_op, ex_rf_we, ex_rf_waddr, ex_result,
        input  data_sram_rvalid, data_sram_rdata,
        output wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
        output fwd_we, fwd_waddr, fwd_wdata, fwd_load_pending
    );

endinterface

// File: rtl/mem_stage_lsu_load_extract.sv
// Combinational load-data extractor.
//   word_i       : returned SRAM word (little-endian)
//   off_i        : byte offset of the load address
//   load_op_i    : load_op encoding (reserved values behave as LW)
//   data_o       : lane-selected, sign/zero-extended load data
//   misaligned_o : address offset illegal for this access size
module mem_stage_lsu_load_extract
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        load_op_i,
    output logic [DATA_W-1:0] data_o,
    output logic              misaligned_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection: byte lane = off, halfword lane = off[1]
    always_comb begin
        case (off_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            default: byte_s = word_i[31:24];
        endcase
        if (off_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
    end

    // Extension to the full datapath width; fill first, then overlay the lane
    always_comb begin
        data_o = '0;
        case (load_op_i)
            LOAD_LB: begin
                data_o      = {DATA_W{byte_s[7]}};
                data_o[7:0] = byte_s;
            end
            LOAD_LBU: data_o[7:0] = byte_s;
            LOAD_LH: begin
                data_o       = {DATA_W{half_s[15]}};
                data_o[15:0] = half_s;
            end
            LOAD_LHU: data_o[15:0] = half_s;
            default:  data_o[31:0] = word_i[31:0];
        endcase
    end

    assign misaligned_o = load_misaligned(load_op_i, off_i);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with sub-word loads and a variable-latency SRAM wait.
//   clk, rst     : clock, synchronous active-high reset
//   stall_i      : shared stall bus (1 = stop)
//   stallreq_o   : MEM holds an outstanding load and needs the pipe frozen
//   mem_adel_o   : current slot is a misaligned load
//   bus (slave)  : EX inputs, SRAM read return, WB and forwarding outputs
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int RF_AW         = 5,
    parameter int STALL_W       = 6,
    parameter int MEM_STALL_BIT = MEM_STALL_BIT_DEF,
    parameter int WB_STALL_BIT  = WB_STALL_BIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    output logic               stallreq_o,
    output logic               mem_adel_o,
    mem_stage_lsu_if.slave     bus
);

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic              mem_ren_q, mem_ren_d;
    logic [2:0]        load_op_q, load_op_d;
    logic              rf_we_q, rf_we_d;
    logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    lsu_state_e        state_q, state_d;

    logic              bubble_s;
    logic              capture_s;
    logic              ex_adel_s;
    logic              adel_s;
    logic              is_load_s;
    logic              waiting_s;
    logic [DATA_W-1:0] ext_data_s;

    // MEM frozen while WB moves on: the slot empties rather than repeating
    assign bubble_s  = stall_i[MEM_STALL_BIT] & ~stall_i[WB_STALL_BIT];
    assign capture_s = ~stall_i[MEM_STALL_BIT];
    assign ex_adel_s = load_misaligned(bus.ex_load_op, bus.ex_result[1:0]);

    // Slot register and load FSM state
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= 32'd0;
            mem_ren_q  <= 1'b0;
            load_op_q  <= 3'd0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            result_q   <= '0;
            rdata_q    <= '0;
            state_q    <= ST_IDLE;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            mem_ren_q  <= mem_ren_d;
            load_op_q  <= load_op_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            result_q   <= result_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
        end
    end

    // Next slot contents and FSM state: bubble, capture, else hold
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        mem_ren_d  = mem_ren_q;
        load_op_d  = load_op_q;
        rf_we_d    = rf_we_q;
        rf_waddr_d = rf_waddr_q;
        result_d   = result_q;
        rdata_d    = rdata_q;
        state_d    = state_q;
        if (bubble_s) begin
            valid_d    = 1'b0;
            pc_d       = 32'd0;
            mem_ren_d  = 1'b0;
            load_op_d  = 3'd0;
            rf_we_d    = 1'b0;
            rf_waddr_d = '0;
            result_d   = '0;
            state_d    = ST_IDLE;
        end else if (capture_s) begin
            valid_d    = bus.ex_valid;
            pc_d       = bus.ex_pc;
            mem_ren_d  = bus.ex_mem_ren;
            load_op_d  = bus.ex_load_op;
            rf_we_d    = bus.ex_rf_we;
            rf_waddr_d = bus.ex_rf_waddr;
            result_d   = bus.ex_result;
            // Misaligned loads never issue, so they never wait
            if (bus.ex_valid && bus.ex_mem_ren && !ex_adel_s) begin
                state_d = ST_WAIT;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q == ST_WAIT) && bus.data_sram_rvalid) begin
            rdata_d = bus.data_sram_rdata;
            state_d = ST_DONE;
        end else begin
            state_d = state_q;
        end
    end

    mem_stage_lsu_load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .word_i       (rdata_q),
        .off_i        (result_q[1:0]),
        .load_op_i    (load_op_q),
        .data_o       (ext_data_s),
        .misaligned_o (adel_s)
    );

    assign is_load_s  = valid_q & mem_ren_q;
    assign waiting_s  = (state_q == ST_WAIT);
    assign stallreq_o = waiting_s;
    assign mem_adel_o = is_load_s & adel_s;

    assign bus.wb_valid         = valid_q & ~waiting_s;
    assign bus.wb_pc            = pc_q;
    assign bus.wb_rf_we         = rf_we_q & ~waiting_s & ~mem_adel_o;
    assign bus.wb_rf_waddr      = rf_waddr_q;
    assign bus.wb_rf_wdata      = (is_load_s && (state_q == ST_DONE)) ? ext_data_s : result_q;
    assign bus.fwd_we           = bus.wb_rf_we;
    assign bus.fwd_waddr        = bus.wb_rf_waddr;
    assign bus.fwd_wdata        = bus.wb_rf_wdata;
    assign bus.fwd_load_pending = waiting_s & rf_we_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic       clk;
    logic       rst;
    logic [5:0] stall;
    logic       stallreq;
    logic       mem_adel;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mem_stage_lsu_if #(.DATA_W(32), .RF_AW(5)) bus ();

    mem_stage_lsu #(
        .DATA_W(32), .RF_AW(5), .STALL_W(6), .MEM_STALL_BIT(3), .WB_STALL_BIT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .stallreq_o (stallreq),
        .mem_adel_o (mem_adel),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_valid = 1'b0, m_ren = 1'b0, m_we = 1'b0;
    logic [31:0] m_pc = 32'd0, m_result = 32'd0, m_data = 32'd0;
    logic [2:0]  m_op = 3'd0;
    logic [4:0]  m_waddr = 5'd0;
    logic        m_wait = 1'b0, m_have = 1'b0;

    logic        e_mis, e_we;
    logic [31:0] e_wdata = 32'd0;

    function automatic bit exp_aligned(input logic [2:0] op, input logic [31:0] addr);
        if (op == 3'd1 || op == 3'd2) return 1'b1;
        if (op == 3'd3 || op == 3'd4) return (addr % 2) == 0;
        return (addr % 4) == 0;
    endfunction

    function automatic logic [31:0] exp_extract(input logic [2:0] op, input logic [31:0] addr,
                                                input logic [31:0] w);
        logic [31:0] v;
        if (op == 3'd1 || op == 3'd2) begin
            v = (w >> (8 * (addr % 4))) & 32'hFF;
            if (op == 3'd1 && v >= 32'd128) v = v - 32'd256;
        end else if (op == 3'd3 || op == 3'd4) begin
            v = (w >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
            if (op == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0; m_ren <= 1'b0; m_we <= 1'b0; m_pc <= 32'd0;
            m_result <= 32'd0; m_op <= 3'd0; m_waddr <= 5'd0;
            m_wait <= 1'b0; m_have <= 1'b0; m_data <= 32'd0;
        end else if (stall[3] && !stall[4]) begin
            m_valid <= 1'b0; m_ren <= 1'b0; m_we <= 1'b0; m_pc <= 32'd0;
            m_result <= 32'd0; m_op <= 3'd0; m_waddr <= 5'd0;
            m_wait <= 1'b0; m_have <= 1'b0;
        end else if (!stall[3]) begin
            m_valid <= bus.ex_valid; m_ren <= bus.ex_mem_ren; m_we <= bus.ex_rf_we;
            m_pc <= bus.ex_pc; m_result <= bus.ex_result; m_op <= bus.ex_load_op;
            m_waddr <= bus.ex_rf_waddr;
            m_wait <= bus.ex_valid && bus.ex_mem_ren && exp_aligned(bus.ex_load_op, bus.ex_result);
            m_have <= 1'b0;
        end else if (m_wait && bus.data_sram_rvalid) begin
            m_wait <= 1'b0; m_have <= 1'b1; m_data <= bus.data_sram_rdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // per-cycle compare of every output against the model
    always begin
        @(posedge clk);
        #1;
        e_mis   = m_valid && m_ren && !exp_aligned(m_op, m_result);
        e_we    = m_we && !m_wait && !e_mis;
        e_wdata = (m_valid && m_ren && m_have) ? exp_extract(m_op, m_result, m_data) : m_result;
        if (chk_en) begin
            chk("stallreq", 32'(stallreq), 32'(m_wait));
            chk("mem_adel", 32'(mem_adel), 32'(e_mis));
            chk("wb_valid", 32'(bus.wb_valid), 32'(m_valid && !m_wait));
            chk("wb_pc", bus.wb_pc, m_pc);
            chk("wb_rf_we", 32'(bus.wb_rf_we), 32'(e_we));
            chk("wb_rf_waddr", 32'(bus.wb_rf_waddr), 32'(m_waddr));
            chk("wb_rf_wdata", bus.wb_rf_wdata, e_wdata);
            chk("fwd_we", 32'(bus.fwd_we), 32'(e_we));
            chk("fwd_waddr", 32'(bus.fwd_waddr), 32'(m_waddr));
            chk("fwd_wdata", bus.fwd_wdata, e_wdata);
            chk("fwd_load_pending", 32'(bus.fwd_load_pending), 32'(m_wait && m_we));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ex(input logic v, input logic ren, input logic [2:0] op, input logic we,
                          input logic [4:0] wa, input logic [31:0] pc, input logic [31:0] res);
        bus.ex_valid = v; bus.ex_mem_ren = ren; bus.ex_load_op = op; bus.ex_rf_we = we;
        bus.ex_rf_waddr = wa; bus.ex_pc = pc; bus.ex_result = res;
    endtask

    task automatic ex_idle();
        set_ex(1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic do_load(input logic [2:0] op, input logic [31:0] res, input logic [31:0] data,
                           input logic [31:0] exp, input string name);
        set_ex(1'b1, 1'b1, op, 1'b1, 5'd7, 32'h0000_0200, res);
        stall = 6'h00;
        step();
        ex_idle();
        stall = 6'h1F;
        bus.data_sram_rvalid = 1'b1;
        bus.data_sram_rdata  = data;
        step();
        bus.data_sram_rvalid = 1'b0;
        chk(name, bus.wb_rf_wdata, exp);
        chk({name, "_model"}, e_wdata, exp);
        stall = 6'h00;
        step();
    endtask

    initial begin
        rst = 1'b1;
        stall = 6'h00;
        ex_idle();
        bus.data_sram_rvalid = 1'b0;
        bus.data_sram_rdata  = 32'd0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wdata", bus.wb_rf_wdata, 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);

        // LW with 3-cycle SRAM latency
        set_ex(1'b1, 1'b1, 3'd0, 1'b1, 5'd9, 32'h0000_0100, 32'h0000_1000);
        step();
        chk("lw_stall1", 32'(stallreq), 32'd1);
        chk("lw_pending", 32'(bus.fwd_load_pending), 32'd1);
        ex_idle();
        stall = 6'h1F;
        step();
        chk("lw_stall2", 32'(stallreq), 32'd1);
        step();
        chk("lw_stall3", 32'(stallreq), 32'd1);
        bus.data_sram_rvalid = 1'b1;
        bus.data_sram_rdata  = 32'hDEAD_BEEF;
        step();
        bus.data_sram_rvalid = 1'b0;
        chk("lw_stall_end", 32'(stallreq), 32'd0);
        chk("lw_wdata", bus.wb_rf_wdata, 32'hDEAD_BEEF);
        chk("lw_we", 32'(bus.wb_rf_we), 32'd1);
        stall = 6'h00;
        step();

        // sub-word loads
        do_load(3'd1, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, "lb_off3");
        do_load(3'd2, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080, "lbu_off3");
        do_load(3'd3, 32'h0000_1002, 32'h80FF_1234, 32'hFFFF_80FF, "lh_off2");
        do_load(3'd4, 32'h0000_1000, 32'h80FF_1234, 32'h0000_1234, "lhu_off0");

        // misaligned LH
        set_ex(1'b1, 1'b1, 3'd3, 1'b1, 5'd4, 32'h0000_0300, 32'h0000_1001);
        step();
        chk("adel_flag", 32'(mem_adel), 32'd1);
        chk("adel_we", 32'(bus.wb_rf_we), 32'd0);
        chk("adel_stallreq", 32'(stallreq), 32'd0);
        ex_idle();
        step();

        // non-load ADD, then a bubble
        set_ex(1'b1, 1'b0, 3'd0, 1'b1, 5'd3, 32'h0000_0400, 32'h0000_0005);
        step();
        chk("add_wdata", bus.wb_rf_wdata, 32'h0000_0005);
        chk("add_fwd_wdata", bus.fwd_wdata, 32'h0000_0005);
        chk("add_fwd_we", 32'(bus.fwd_we), 32'd1);
        stall = 6'h08;
        step();
        chk("bubble_valid", 32'(bus.wb_valid), 32'd0);
        chk("bubble_we", 32'(bus.wb_rf_we), 32'd0);
        stall = 6'h00;
        ex_idle();

        // reset while waiting, then a late rvalid
        set_ex(1'b1, 1'b1, 3'd0, 1'b1, 5'd6, 32'h0000_0500, 32'h0000_2000);
        step();
        chk("rstw_stall", 32'(stallreq), 32'd1);
        ex_idle();
        stall = 6'h1F;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_stallreq", 32'(stallreq), 32'd0);
        bus.data_sram_rvalid = 1'b1;
        bus.data_sram_rdata  = 32'h1234_5678;
        step();
        bus.data_sram_rvalid = 1'b0;
        chk("rstw_wdata", bus.wb_rf_wdata, 32'd0);
        chk("rstw_valid", 32'(bus.wb_valid), 32'd0);
        chk("rstw_stallreq2", 32'(stallreq), 32'd0);
        stall = 6'h00;
        step();

        // stray rvalid while idle
        bus.data_sram_rvalid = 1'b1;
        bus.data_sram_rdata  = 32'hAAAA_5555;
        step();
        bus.data_sram_rvalid = 1'b0;
        chk("stray_wdata", bus.wb_rf_wdata, 32'd0);
        do_load(3'd0, 32'h0000_3000, 32'hCAFE_F00D, 32'hCAFE_F00D, "lw_after_stray");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (m_wait) begin
                stall = ($urandom_range(0, 19) == 0) ? 6'h08 : 6'h1F;
                bus.data_sram_rvalid = ($urandom_range(0, 2) == 0);
            end else begin
                case ($urandom_range(0, 7))
                    0:       stall = 6'h08;
                    1:       stall = 6'h18;
                    default: stall = 6'h00;
                endcase
                bus.data_sram_rvalid = ($urandom_range(0, 15) == 0);
            end
            bus.data_sram_rdata = $urandom;
            set_ex($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom, $urandom);
            step();
        end

        rst = 1'b0;
        bus.data_sram_rvalid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
